// File: rtl/apb_slave_array_if.sv
// ---------------------------------------------------------------------------
// apb_slave_array_if
// Purpose : APB bus bundle shared by the bridge's APB master side and the
//           apb_slave_array register-file targets.
// Signals : pselx   - one select bit per slave (one-hot expected)
//           penable - ACCESS phase qualifier
//           pwrite  - 1 = write, 0 = read
//           paddr   - byte address
//           pwdata  - write data
//           pready  - transfer completes this cycle
//           prdata  - read data, valid when pready & !pwrite
//           pslverr - error flag, valid when pready
// Modports: master drives the request side, slave drives the response side.
// ---------------------------------------------------------------------------
interface apb_slave_array_if #(
  parameter int NUM_SLAVES = 3,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32
);
  logic [NUM_SLAVES-1:0] pselx;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic                  pready;
  logic [DATA_W-1:0]     prdata;
  logic                  pslverr;

  modport master (
    output pselx, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  pselx, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_slave_array.sv
// ---------------------------------------------------------------------------
// apb_slave_array
// Purpose : Array of NUM_SLAVES APB register-file targets (one per pselx bit)
//           with programmable wait states and an error response. Used as the
//           APB-side target of the AHB-APB bridge in system benches.
// Ports   : hclk    - clock, rising edge
//           hresetn - asynchronous active-low reset (clears FSM and storage)
//           bus     - apb_slave_array_if.slave (pselx/penable/pwrite/paddr/
//                     pwdata in; pready/prdata/pslverr out)
// Option  : APB_SLVERR_RANGE_EN - when defined, nonzero paddr bits at or
//           above ADDR_LSB+IDX_W flag the access as out of range (pslverr,
//           no write, prdata=0). When undefined, those bits are ignored and
//           addresses alias modulo DEPTH words.
// ---------------------------------------------------------------------------
module apb_slave_array #(
  parameter int NUM_SLAVES  = 3,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 16,
  parameter int ADDR_LSB    = 2,
  parameter int WAIT_STATES = 0
) (
  input logic               hclk,
  input logic               hresetn,
  apb_slave_array_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WAIT_MAX = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state_q, state_d;

  logic [3:0]            wait_cnt;
  logic [NUM_SLAVES-1:0] sel_q;
  logic                  write_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_W-1:0]     mem [NUM_SLAVES][DEPTH];

  logic                  latch;
  logic                  complete;
  logic                  sel_onehot;
  logic                  addr_err;
  logic                  xfer_err;
  logic [DATA_W-1:0]     rd_word;

  // State register; reset drops any transfer in flight.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. pready depends only on registered state, so the
  // completion cycle wins over a simultaneous drop of pselx/penable.
  always_comb begin
    state_d  = state_q;
    latch    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.pselx && !bus.penable) state_d = SETUP;
      end
      SETUP: begin
        if (bus.pselx == '0) begin
          state_d = IDLE;
        end else if (bus.penable) begin
          state_d = ACCESS;
          latch   = 1'b1;
        end
      end
      ACCESS: begin
        if (wait_cnt == WAIT_MAX) begin
          complete = 1'b1;
          state_d  = (|bus.pselx && !bus.penable) ? SETUP : IDLE;
        end else if (bus.pselx == '0 || !bus.penable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture at the SETUP->ACCESS edge plus the wait-state counter.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wait_cnt <= '0;
      sel_q    <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      idx_q    <= '0;
    end else if (latch) begin
      wait_cnt <= '0;
      sel_q    <= bus.pselx;
      write_q  <= bus.pwrite;
      wdata_q  <= bus.pwdata;
      idx_q    <= bus.paddr[ADDR_LSB +: IDX_W];
    end else if (state_q == ACCESS && wait_cnt < WAIT_MAX) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

`ifdef APB_SLVERR_RANGE_EN
  logic oor_q;

  // Any address bit above the word index makes the access out of range.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      oor_q <= 1'b0;
    end else if (latch) begin
      oor_q <= |(bus.paddr >> (ADDR_LSB + IDX_W));
    end
  end

  assign addr_err = oor_q;
`else
  assign addr_err = 1'b0;
`endif

  // A select with several bits set (or none) is rejected as a bad select.
  assign sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - 1'b1)) == '0);
  assign xfer_err   = !sel_onehot || addr_err;

  // Storage: written only on a clean completing write to the latched slave.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int s = 0; s < NUM_SLAVES; s++) begin
        for (int w = 0; w < DEPTH; w++) begin
          mem[s][w] <= '0;
        end
      end
    end else if (complete && write_q && !xfer_err) begin
      for (int s = 0; s < NUM_SLAVES; s++) begin
        if (sel_q[s]) mem[s][idx_q] <= wdata_q;
      end
    end
  end

  // Read mux; OR-combined since only a one-hot select ever reaches prdata.
  always_comb begin
    rd_word = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (sel_q[s]) rd_word = rd_word | mem[s][idx_q];
    end
  end

  assign bus.pready  = complete;
  assign bus.pslverr = complete && xfer_err;
  assign bus.prdata  = (complete && !write_q && !xfer_err) ? rd_word : '0;

endmodule

// File: tb/tb_apb_slave_array.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_array
// Randomized self-checking bench for apb_slave_array with WAIT_STATES=2.
// A word-array reference model predicts pslverr, read data and latency for
// every transfer; directed sequences cover reset, bad select, range/alias,
// abort, back-to-back transfers and reset in the middle of a completion.
// ---------------------------------------------------------------------------
module tb_apb_slave_array;

  localparam int NS    = 3;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 16;
  localparam int WS    = 2;

  logic hclk;
  logic hresetn;

  int checkCount = 0;
  int errorCount = 0;

  logic [DW-1:0] model [NS][DEPTH];

  apb_slave_array_if #(.NUM_SLAVES(NS), .DATA_W(DW), .ADDR_W(AW)) bus ();

  apb_slave_array #(
    .NUM_SLAVES (NS),
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .DEPTH      (DEPTH),
    .ADDR_LSB   (2),
    .WAIT_STATES(WS)
  ) dut (
    .hclk   (hclk),
    .hresetn(hresetn),
    .bus    (bus)
  );

  // Free-running 100 MHz clock
  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  // Backstop in case a bounded loop is ever miscoded
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Clear the reference storage, mirroring a hardware reset
  task automatic clearModel();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < DEPTH; w++)
        model[s][w] = '0;
  endtask

  // Predict the response of one transfer from the addressing rules
  task automatic predict(input logic [NS-1:0] sel, input logic [AW-1:0] addr,
                         output logic expErr, output int slv, output int idx);
    slv = 0;
    for (int s = 0; s < NS; s++) if (sel[s]) slv = s;
    idx = int'((addr / 4) % DEPTH);
    expErr = ($countones(sel) != 1);
`ifdef APB_SLVERR_RANGE_EN
    if ((addr / (4 * DEPTH)) != 0) expErr = 1'b1;
`endif
  endtask

  // Return the bus to idle for n cycles
  task automatic idleBus(input int n);
    bus.pselx   = '0;
    bus.penable = 1'b0;
    repeat (n) begin
      @(posedge hclk); #1;
    end
  endtask

  // Drive one full APB transfer; returns at 1 ns after the completion edge
  // with the bus still in ACCESS so a caller can chain the next SETUP.
  task automatic applyStimulus(input logic [NS-1:0] sel, input logic wr,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               output logic [DW-1:0] rdata, output logic err,
                               output int lat, output logic done);
    bus.pselx   = sel;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = wdata;
    @(posedge hclk); #1;
    bus.penable = 1'b1;
    lat   = 0;
    done  = 1'b0;
    rdata = '0;
    err   = 1'b0;
    while (!done && lat < 40) begin
      @(negedge hclk);
      if (bus.pready) begin
        rdata = bus.prdata;
        err   = bus.pslverr;
        done  = 1'b1;
      end else begin
        checkOutput("pslverr_while_waiting", 32'(bus.pslverr), 32'd0);
      end
      @(posedge hclk); #1;
      lat++;
    end
  endtask

  // One transfer checked against the model; the model absorbs clean writes
  task automatic runTransfer(input logic [NS-1:0] sel, input logic wr,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    logic [DW-1:0] rdata;
    logic          err;
    logic          done;
    logic          expErr;
    int            lat;
    int            slv;
    int            idx;
    predict(sel, addr, expErr, slv, idx);
    applyStimulus(sel, wr, addr, wdata, rdata, err, lat, done);
    checkOutput("completed", 32'(done), 32'd1);
    checkOutput("latency", 32'(lat), 32'(WS + 2));
    checkOutput("pslverr", 32'(err), 32'(expErr));
    if (!wr) checkOutput("prdata", rdata, expErr ? 32'd0 : model[slv][idx]);
    if (wr && !expErr) model[slv][idx] = wdata;
  endtask

  initial begin
    logic [NS-1:0] badSel [4];
    logic [NS-1:0] sel;
    logic [AW-1:0] addr;
    logic          wr;
    badSel[0] = 3'b011; badSel[1] = 3'b101; badSel[2] = 3'b110; badSel[3] = 3'b111;

    bus.pselx   = '0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
    clearModel();

    // Reset state
    hresetn = 1'b0;
    repeat (3) @(posedge hclk);
    #1;
    checkOutput("reset_pready", 32'(bus.pready), 32'd0);
    checkOutput("reset_prdata", bus.prdata, 32'd0);
    checkOutput("reset_pslverr", 32'(bus.pslverr), 32'd0);
    hresetn = 1'b1;
    idleBus(2);

    // Basic write/readback on slave1, word 2
    runTransfer(3'b010, 1'b1, 32'h8, 32'hDEADBEEF);
    runTransfer(3'b010, 1'b0, 32'h8, 32'h0);
    // Unaligned address maps to the same word
    runTransfer(3'b010, 1'b0, 32'hB, 32'h0);
    idleBus(1);

    // Bad select: error and nothing written anywhere
    runTransfer(3'b011, 1'b1, 32'h4, 32'h1234);
    runTransfer(3'b001, 1'b0, 32'h4, 32'h0);
    runTransfer(3'b010, 1'b0, 32'h4, 32'h0);
    idleBus(1);

    // Range check vs aliasing at paddr 0x40
    runTransfer(3'b100, 1'b1, 32'h40, 32'hCAFE0001);
    runTransfer(3'b100, 1'b0, 32'h0, 32'h0);
    runTransfer(3'b100, 1'b0, 32'h40, 32'h0);
    idleBus(2);

    // Abort during a wait state leaves the target word untouched
    runTransfer(3'b001, 1'b1, 32'h10, 32'h0BADF00D);
    idleBus(1);
    bus.pselx   = 3'b001;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b1;
    bus.paddr   = 32'h10;
    bus.pwdata  = 32'h55AA55AA;
    @(posedge hclk); #1;
    bus.penable = 1'b1;
    repeat (2) begin
      @(negedge hclk);
      checkOutput("abort_pready_before_drop", 32'(bus.pready), 32'd0);
      @(posedge hclk); #1;
    end
    bus.pselx   = '0;
    bus.penable = 1'b0;
    repeat (3) begin
      @(negedge hclk);
      checkOutput("abort_pready_after_drop", 32'(bus.pready), 32'd0);
      @(posedge hclk); #1;
    end
    // Back-to-back reads, no idle cycle between them
    runTransfer(3'b001, 1'b0, 32'h10, 32'h0);
    runTransfer(3'b010, 1'b0, 32'h8, 32'h0);
    runTransfer(3'b001, 1'b0, 32'h10, 32'h0);
    idleBus(1);

    // Randomized traffic against the model
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(7) == 0) sel = badSel[$urandom_range(3)];
      else                        sel = NS'(1) << $urandom_range(NS - 1);
      if ($urandom_range(3) == 0) addr = $urandom;
      else                        addr = AW'($urandom_range(63));
      wr = 1'($urandom_range(1));
      runTransfer(sel, wr, addr, $urandom);
      if ($urandom_range(1) == 0) idleBus($urandom_range(2));
    end
    idleBus(1);

    // Reset asserted during the completion cycle of a read of nonzero data
    runTransfer(3'b100, 1'b1, 32'h20, 32'hA5A55A5A);
    idleBus(1);
    bus.pselx   = 3'b100;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = 32'h20;
    @(posedge hclk); #1;
    bus.penable = 1'b1;
    repeat (WS + 1) begin
      @(posedge hclk); #1;
    end
    checkOutput("pre_reset_pready", 32'(bus.pready), 32'd1);
    checkOutput("pre_reset_prdata", bus.prdata, 32'hA5A55A5A);
    #2;
    hresetn = 1'b0;
    #1;
    checkOutput("midxfer_reset_pready", 32'(bus.pready), 32'd0);
    checkOutput("midxfer_reset_prdata", bus.prdata, 32'd0);
    checkOutput("midxfer_reset_pslverr", 32'(bus.pslverr), 32'd0);
    clearModel();
    @(negedge hclk);
    hresetn = 1'b1;
    // penable held high while the FSM is idle must be ignored
    repeat (3) begin
      @(negedge hclk);
      checkOutput("penable_in_idle_pready", 32'(bus.pready), 32'd0);
    end
    @(posedge hclk); #1;
    idleBus(1);
    runTransfer(3'b100, 1'b0, 32'h20, 32'h0);
    runTransfer(3'b010, 1'b0, 32'h8, 32'h0);
    runTransfer(3'b001, 1'b0, 32'h10, 32'h0);
    idleBus(2);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
